// File: rtl/div_sched_if.sv
// Configuration/run-control bundle for div_sched.
// cfg_valid/cfg_ready: a config transfers on any rising edge where both are 1; cfg_div is held with cfg_valid until then.
interface div_sched_if #(parameter int W = 8);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         start;
  logic         stop;
  logic         y;
  logic         tick;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  modport slave (
    input  cfg_valid, cfg_div, start, stop,
    output cfg_ready, y, tick, busy, err, dbg_state
  );

  modport master (
    output cfg_valid, cfg_div, start, stop,
    input  cfg_ready, y, tick, busy, err, dbg_state
  );
endinterface

// File: rtl/div_sched.sv
// Programmable period scheduler: y marks the first cycle and tick the last cycle of
// each N-cycle period; a stop request always lets the current period complete.
module div_sched #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        reset,
  div_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_RUN      = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         err_q, err_d;

  logic         busy;
  logic         last;
  logic         accept;
  logic         legal;
  logic [W-1:0] cnt_inc;

  assign busy    = (state_q == S_RUN) || (state_q == S_STOPPING);
  assign last    = (cnt_q == div_q - ONE);
  assign accept  = bus.cfg_valid && !busy;
  assign legal   = (bus.cfg_div > ONE);
  // Wrap at div_q-1 keeps cnt below 2^W-1 even for the largest divisor.
  assign cnt_inc = last ? '0 : cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_ARMED: begin
        cnt_d = '0;
        if (accept) begin
          if (legal) begin
            div_d   = bus.cfg_div;
            err_d   = 1'b0;
            state_d = S_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end else if ((state_q == S_ARMED) && bus.start && !bus.stop) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (bus.stop) state_d = last ? S_ARMED : S_STOPPING;
      end
      S_STOPPING: begin
        cnt_d = cnt_inc;
        if (last) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  assign bus.y         = busy && (cnt_q == '0);
  assign bus.tick      = busy && last;
  assign bus.busy      = busy;
  assign bus.cfg_ready = !busy;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed vector table, hand-written long/abort sequences and
// randomized traffic, all checked against a period-arithmetic reference model.
module tb_div_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_sched_if #(.W(W)) bus ();
  div_sched #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests  = 0;
  int failed = 0;

  // Reference model: a run is described by its first cycle and divisor; phase is arithmetic.
  int cyc = 0;
  bit m_run = 0, m_stopping = 0, m_armed = 0, m_err = 0;
  int m_div = 0, m_t0 = 0;

  logic [4:0] exp_q[$];
  logic [4:0] cur;

  typedef struct {
    int           reps;
    logic         v;
    logic [W-1:0] d;
    logic         s;
    logic         p;
    logic         r;
    logic [4:0]   exp;
    string        name;
  } vec_t;
  vec_t vq[$];

  function automatic int phase();
    return (cyc - m_t0) % m_div;
  endfunction

  function automatic logic [4:0] model_out();
    if (!m_run) return {3'b000, 1'b1, m_err};
    return {phase() == 0, phase() == m_div - 1, 1'b1, 1'b0, m_err};
  endfunction

  function automatic void model_update(logic v, logic [W-1:0] d, logic s, logic p, logic r);
    bit lastp;
    if (!r) begin
      m_run = 0; m_stopping = 0; m_armed = 0; m_div = 0; m_err = 0;
    end else if (m_run) begin
      lastp = (phase() == m_div - 1);
      if (m_stopping) begin
        if (lastp) begin m_run = 0; m_stopping = 0; m_armed = 1; end
      end else if (p) begin
        if (lastp) begin m_run = 0; m_armed = 1; end
        else m_stopping = 1;
      end
    end else if (v) begin
      if (int'(d) >= 2) begin m_div = int'(d); m_err = 0; m_armed = 1; end
      else m_err = 1;
    end else if (m_armed && s && !p) begin
      m_run = 1; m_t0 = cyc + 1;
    end
    cyc++;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d {y,tick,busy,rdy,err} got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic s, input logic p, input logic r);
    bus.cfg_valid = v; bus.cfg_div = d; bus.start = s; bus.stop = p; reset = r;
    @(posedge clk);
    #1;
    model_update(v, d, s, p, r);
    exp_q.push_back(model_out());
    @(negedge clk);
    cur = {bus.y, bus.tick, bus.busy, bus.cfg_ready, bus.err};
    check("model", cur, exp_q.pop_front());
  endtask

  function automatic void add(int reps, logic v, logic [W-1:0] d, logic s, logic p, logic r,
                              logic [4:0] exp, string name);
    vec_t t;
    t.reps = reps; t.v = v; t.d = d; t.s = s; t.p = p; t.r = r; t.exp = exp; t.name = name;
    vq.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ys[$];
    int ts[$];
    int n;
    logic         v, s, p, r;
    logic [W-1:0] d;

    // reps, v, d, s, p, r, {y,tick,busy,rdy,err}
    add(2,  0, 0, 0, 0, 0, 5'b00010, "reset");
    add(10, 0, 0, 1, 0, 1, 5'b00010, "idle_start_ignored");
    add(1,  1, 3, 0, 0, 1, 5'b00010, "cfg3");
    add(1,  0, 0, 1, 0, 1, 5'b10100, "t+1_y");
    add(1,  0, 0, 0, 0, 1, 5'b00100, "t+2");
    add(1,  0, 0, 0, 0, 1, 5'b01100, "t+3_tick");
    add(1,  0, 0, 0, 0, 1, 5'b10100, "t+4_y");
    add(1,  0, 0, 0, 0, 1, 5'b00100, "t+5");
    add(1,  0, 0, 0, 0, 1, 5'b01100, "t+6_tick");
    add(1,  0, 0, 0, 0, 1, 5'b10100, "t+7_y");
    add(1,  0, 0, 0, 1, 1, 5'b00100, "stop_at_cnt0");
    add(1,  0, 0, 1, 1, 1, 5'b01100, "stopping_tick");
    add(1,  0, 0, 0, 0, 1, 5'b00010, "back_armed");
    add(1,  0, 0, 1, 0, 1, 5'b10100, "restart_y");
    add(1,  0, 0, 0, 0, 1, 5'b00100, "restart_cnt1");
    add(1,  0, 0, 0, 0, 1, 5'b01100, "restart_tick");
    add(1,  0, 0, 0, 1, 1, 5'b00010, "stop_at_last");
    add(1,  0, 0, 1, 1, 1, 5'b00010, "stop_wins");
    add(1,  1, 4, 1, 0, 1, 5'b00010, "cfg_beats_start");
    add(1,  0, 0, 0, 0, 0, 5'b00010, "reset2");
    add(1,  1, 1, 0, 0, 1, 5'b00011, "illegal_div1");
    add(1,  0, 0, 1, 0, 1, 5'b00011, "idle_err_start");
    add(1,  1, 5, 0, 0, 1, 5'b00010, "cfg5_clears_err");
    add(1,  0, 0, 1, 0, 1, 5'b10100, "n5_y");
    add(3,  0, 0, 0, 0, 1, 5'b00100, "n5_mid");
    add(1,  0, 0, 0, 0, 1, 5'b01100, "n5_tick");
    add(1,  0, 0, 0, 0, 1, 5'b10100, "n5_y2");
    add(1,  0, 0, 0, 0, 1, 5'b00100, "n5_cnt1");
    add(1,  0, 0, 0, 0, 0, 5'b00010, "reset_mid_run");
    add(1,  0, 0, 1, 0, 1, 5'b00010, "start_needs_cfg");

    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].reps; k++) begin
        cycle(vq[i].v, vq[i].d, vq[i].s, vq[i].p, vq[i].r);
        check(vq[i].name, cur, vq[i].exp);
      end
    end

    // Reset at cnt=1 of an N=3 run: aborts with no completion tick.
    cycle(1, 3, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("n3_cnt1", cur, 5'b00100);
    cycle(0, 0, 0, 0, 0);
    check("n3_reset_abort", cur, 5'b00010);
    cycle(0, 0, 0, 0, 1);
    check("n3_no_tick_after", cur, 5'b00010);

    // Largest divisor, with a competing config held throughout the run.
    cycle(1, 255, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    if (cur[4]) ys.push_back(cyc);
    for (int k = 0; k < 599; k++) begin
      cycle(1, 4, 0, 0, 1);
      check("n255_not_ready", {4'b0000, cur[1]}, 5'b00000);
      if (cur[4]) ys.push_back(cyc);
    end
    check_int("n255_y_count", ys.size(), 3);
    for (int k = 1; k < ys.size(); k++) check_int("n255_y_spacing", ys[k] - ys[k-1], 255);

    cycle(1, 4, 0, 1, 1);
    n = 0;
    while (cur[2] && n < 300) begin
      cycle(1, 4, 0, 0, 1);
      n++;
    end
    check_int("n255_stop_done", int'(cur[2]), 0);
    cycle(1, 4, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (cur[3]) ts.push_back(cyc);
    end
    check_int("n4_tick_count", ts.size(), 2);
    if (ts.size() == 2) check_int("n4_tick_spacing", ts[1] - ts[0], 4);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       d = '0;
        1:       d = W'(1);
        2:       d = W'(2);
        3:       d = W'(3);
        default: d = W'($urandom_range(2, 20));
      endcase
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 299) != 0);
      cycle(v, d, s, p, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
